// File: rtl/seg7_scan_controller.sv
// seg7_scan_controller: N-digit common-anode 7-segment scanner with blank interval and double-buffered load
// Define LEADING_ZERO_BLANK_EN to blank leading zero digits (digit 0 always shown).
module seg7_scan_controller #(
  parameter int NUM_DIGITS = 4,
  parameter int TICK_DIV = 50000,
  parameter int BLANK_CYC = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic load_valid,
  output logic load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_bcd,
  input  logic [NUM_DIGITS-1:0] load_dp,
  output logic [7:0] seg,
  output logic [NUM_DIGITS-1:0] an,
  output logic frame_done
);
  localparam int CW = $clog2(TICK_DIV);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  typedef enum logic {BLANK, SHOW} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [IW-1:0] idx, idx_nxt;
  logic pend, wrap, commit;
  logic [4*NUM_DIGITS-1:0] pend_bcd, disp_bcd;
  logic [NUM_DIGITS-1:0] pend_dp, disp_dp, lzb;
  logic [3:0] cur;
  logic [6:0] dec;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= BLANK;
      cnt <= '0;
      idx <= '0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
      idx <= idx_nxt;
    end
  always_comb begin
    state_nxt = state;
    cnt_nxt = cnt == CNT_LAST ? '0 : cnt + 1'b1;
    idx_nxt = idx;
    if (!enable) begin
      state_nxt = BLANK;
      cnt_nxt = '0;
      idx_nxt = '0;
    end else if (state == BLANK)
      state_nxt = cnt == BLANK_LAST ? SHOW : BLANK;
    else if (cnt == CNT_LAST) begin
      state_nxt = BLANK;
      idx_nxt = idx == IDX_LAST ? '0 : idx + 1'b1;
    end
  end
  assign wrap = enable && state == SHOW && cnt == CNT_LAST && idx == IDX_LAST;
  // while dark there is no frame boundary to wait for, so a pending value lands at once
  assign commit = pend && (wrap || !enable);
  assign load_ready = ~pend;
  always_comb begin
    cur = disp_bcd[idx*4 +: 4];
    case (cur)
      4'd0: dec = 7'h40;
      4'd1: dec = 7'h79;
      4'd2: dec = 7'h24;
      4'd3: dec = 7'h30;
      4'd4: dec = 7'h19;
      4'd5: dec = 7'h12;
      4'd6: dec = 7'h02;
      4'd7: dec = 7'h78;
      4'd8: dec = 7'h00;
      4'd9: dec = 7'h10;
      default: dec = 7'h7F;
    endcase
  end
`ifdef LEADING_ZERO_BLANK_EN
  logic lz_run;
  always_comb begin
    lzb = '0;
    lz_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      lz_run = lz_run && disp_bcd[4*i +: 4] == 4'd0 && !disp_dp[i];
      lzb[i] = lz_run;
    end
  end
`else
  assign lzb = '0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      seg <= 8'hFF;
      an <= '1;
      frame_done <= 1'b0;
      pend <= 1'b0;
      pend_bcd <= '0;
      pend_dp <= '0;
      disp_bcd <= '1;
      disp_dp <= '0;
    end else begin
      frame_done <= wrap;
      seg <= enable && state == SHOW ? (lzb[idx] ? 8'hFF : {~disp_dp[idx], dec}) : 8'hFF;
      an <= enable && state == SHOW ? ~(NUM_DIGITS'(1) << idx) : '1;
      if (load_valid && !pend) begin
        pend <= 1'b1;
        pend_bcd <= load_bcd;
        pend_dp <= load_dp;
      end
      if (commit) begin
        pend <= 1'b0;
        disp_bcd <= pend_bcd;
        disp_dp <= pend_dp;
      end
    end
endmodule

// File: tb/tb_seg7_scan_controller.sv
// tb_seg7_scan_controller: directed + random checks of seg7_scan_controller against a time-based display model
module tb_seg7_scan_controller;
  localparam int ND = 4;
  localparam int TD = 8;
  localparam int BC = 2;
  localparam logic [6:0] TBL [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  logic clk = 1'b0;
  logic rst_n, enable, load_valid, load_ready, frame_done;
  logic [15:0] load_bcd;
  logic [3:0] load_dp, an;
  logic [7:0] seg;
  int errors = 0, checks = 0;
  int t;
  bit m_pend, m_cap;
  logic [15:0] p_bcd, d_bcd;
  logic [3:0] p_dp, d_dp, e_an;
  logic [7:0] e_seg;
  logic e_fd;
  seg7_scan_controller #(.NUM_DIGITS(ND), .TICK_DIV(TD), .BLANK_CYC(BC)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .load_valid(load_valid), .load_ready(load_ready),
    .load_bcd(load_bcd), .load_dp(load_dp), .seg(seg), .an(an), .frame_done(frame_done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [7:0] seg_of(input int d);
    logic [3:0] c;
    bit lz;
    c = d_bcd[4*d +: 4];
    lz = d != 0;
    for (int i = ND - 1; i >= d; i--) lz = lz && d_bcd[4*i +: 4] == 4'd0 && !d_dp[i];
`ifndef LEADING_ZERO_BLANK_EN
    lz = 0;
`endif
    return lz ? 8'hFF : {~d_dp[d], c < 10 ? TBL[c] : 7'h7F};
  endfunction
  task automatic model_reset();
    t = 0;
    m_pend = 0;
    m_cap = 0;
    d_bcd = '1;
    d_dp = '0;
    e_seg = 8'hFF;
    e_an = 4'hF;
    e_fd = 0;
  endtask
  task automatic model_step();
    int ph, dg;
    bit wr, cm, cp;
    wr = 0;
    if (enable) begin
      ph = t % TD;
      dg = (t / TD) % ND;
      e_seg = ph >= BC ? seg_of(dg) : 8'hFF;
      e_an = ph >= BC ? ~(4'b1 << dg) : 4'hF;
      wr = ph == TD - 1 && dg == ND - 1;
      t++;
    end else begin
      e_seg = 8'hFF;
      e_an = 4'hF;
      t = 0;
    end
    e_fd = wr;
    cm = m_pend && (wr || !enable);
    cp = load_valid && !m_pend;
    m_cap = cp;
    if (cp) begin
      m_pend = 1;
      p_bcd = load_bcd;
      p_dp = load_dp;
    end
    if (cm) begin
      m_pend = 0;
      d_bcd = p_bcd;
      d_dp = p_dp;
    end
  endtask
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("seg", seg, e_seg);
    chk("an", an, e_an);
    chk("frame_done", frame_done, e_fd);
    chk("load_ready", load_ready, !m_pend);
  endtask
  task automatic wait_an(input logic [3:0] v);
    int n = 0;
    while (an !== v && n < 100) begin
      tick();
      n++;
    end
    chk("wait_an", an, v);
  endtask
  task automatic wait_ready();
    int n = 0;
    while (load_ready !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk("wait_ready", load_ready, 1);
  endtask
  task automatic load(input logic [15:0] b, input logic [3:0] d);
    int n = 0;
    load_bcd = b;
    load_dp = d;
    load_valid = 1;
    do begin
      tick();
      n++;
    end while (!m_cap && n < 100);
    load_valid = 0;
    chk("load_accept", n < 100, 1);
  endtask
  task automatic reset_mid();
    #2 rst_n = 0;
    #1;
    chk("rst_seg", seg, 8'hFF);
    chk("rst_an", an, 4'hF);
    chk("rst_ready", load_ready, 1);
    chk("rst_fd", frame_done, 0);
    @(negedge clk);
    rst_n = 1;
    model_reset();
  endtask
  initial begin
    int n;
    rst_n = 0;
    enable = 0;
    load_valid = 0;
    load_bcd = '0;
    load_dp = '0;
    @(negedge clk);
    chk("init_seg", seg, 8'hFF);
    chk("init_an", an, 4'hF);
    chk("init_ready", load_ready, 1);
    chk("init_fd", frame_done, 0);
    rst_n = 1;
    model_reset();
    enable = 1;
    repeat (10) tick();
    load(16'h1234, 4'h0);
    wait_ready();
    wait_an(4'b1110); chk("d0_1234", seg, 8'h99);
    wait_an(4'b1101); chk("d1_1234", seg, 8'hB0);
    wait_an(4'b1011); chk("d2_1234", seg, 8'hA4);
    wait_an(4'b0111); chk("d3_1234", seg, 8'hF9);
    wait_an(4'b1011);
    load(16'h5678, 4'h0);
    chk("ready_low", load_ready, 0);
    wait_an(4'b0111); chk("d3_old", seg, 8'hF9);
    wait_an(4'b1110); chk("d0_new", seg, 8'h80);
    wait_an(4'b1101);
    load(16'h9999, 4'hF);
    reset_mid();
    wait_an(4'b1110); chk("post_rst_blank", seg, 8'hFF);
    load(16'h000A, 4'b0001);
    wait_ready();
    wait_an(4'b1110); chk("a_dp1", seg, 8'h7F);
    load(16'h000A, 4'b0000);
    wait_ready();
    wait_an(4'b1110); chk("a_dp0", seg, 8'hFF);
    wait_an(4'b1101);
    repeat (2) tick();
    enable = 0;
    tick();
    chk("dis_an", an, 4'hF);
    chk("dis_seg", seg, 8'hFF);
    chk("dis_fd", frame_done, 0);
    repeat (3) tick();
    enable = 1;
    n = 0;
    while (an === 4'hF && n < 20) begin
      tick();
      n++;
    end
    chk("reen_lat", n, 3);
    chk("reen_an", an, 4'b1110);
    load(16'h0070, 4'h0);
    wait_ready();
`ifdef LEADING_ZERO_BLANK_EN
    wait_an(4'b0111); chk("lz_d3", seg, 8'hFF);
    wait_an(4'b1110); chk("lz_d0", seg, 8'hC0);
    wait_an(4'b1101); chk("lz_d1", seg, 8'hF8);
    wait_an(4'b1011); chk("lz_d2", seg, 8'hFF);
`else
    wait_an(4'b0111); chk("nlz_d3", seg, 8'hC0);
    wait_an(4'b1110); chk("nlz_d0", seg, 8'hC0);
    wait_an(4'b1101); chk("nlz_d1", seg, 8'hF8);
    wait_an(4'b1011); chk("nlz_d2", seg, 8'hC0);
`endif
    for (int i = 0; i < 600; i++) begin
      enable = $urandom_range(0, 29) != 0;
      load_valid = $urandom_range(0, 5) == 0;
      load_bcd = 16'($urandom);
      load_dp = 4'($urandom);
      if (i == 300) reset_mid();
      else tick();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
